instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Requester side of the instruction memory interface. It holds the program counter, drives the word address into `instruction_memor`, and captures the returned instruction after the memory's fixed one-cycle read latency. Fetched instructions are buffered in a small FIFO and passed to the decode stage over a valid/ready handshake. Branches and jumps resolved downstream redirect the fetch stream and flush everything in flight.

## Interface
- `WORD_SIZE`, 32: width of the address, instruction and PC.
- `RESET_ADDR`, 0: byte address of the first fetch after reset; bits [1:0] must be 0.
- `DEPTH`, 2: fetch buffer entries; must be at least 2. The counter is wide enough to hold `DEPTH`.
- `clk`, in, 1: the one clock. Everything samples on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `imem_addr`, out, `WORD_SIZE`: byte address to instruction memory (`addres`). Bits [1:0] are always 0.
- `instruction`, in, `WORD_SIZE`: instruction memory read data. It holds the word for the address present before the previous edge.
- `redirect_valid`, in, 1: branch/jump taken this cycle.
- `redirect_addr`, in, `WORD_SIZE`: redirect target. Bits [1:0] are ignored and forced to 0.
- `out_valid`, out, 1: buffer head is valid for decode.
- `out_ready`, in, 1: decode accepts the head.
- `out_instr`, out, `WORD_SIZE`: instruction at the buffer head.
- `out_pc`, out, `WORD_SIZE`: byte address of `out_instr`.

## Operation
State:
- `pc`: drives `imem_addr` directly.
- `inflight` flag and `inflight_pc`.
- FIFO of `DEPTH` {instr, pc} pairs, with `count`.

Per rising edge, in priority order:
1. **Redirect** (`redirect_valid`=1):
   - `count`←0 (all entries flushed).
   - `inflight`←0, so the memory response arriving at the next edge is discarded.
   - `pc`←{`redirect_addr`[W-1:2],2'b00}.
   - No issue and no pop this edge.
2. **Capture**: if `inflight`=1, push {`instruction`, `inflight_pc`} into the FIFO.
3. **Pop**: if `out_valid`&`out_ready`, remove the head.
4. **Issue**:
   - Condition: (`count` + `inflight` − pop) < `DEPTH`. Capture does not free a slot, so this credit check means the FIFO never overflows.
   - On issue: `inflight`←1, `inflight_pc`←`pc`, `pc`←`pc`+4.
   - Otherwise: `inflight`←0 and `pc` holds.

Output and arithmetic rules:
- `out_valid` = (`count`≠0) & ~`redirect_valid`. It is combinational and masks the head during a redirect cycle, so no transfer happens on that cycle.
- `out_instr`/`out_pc` reflect the head entry and are meaningful only when `out_valid`=1.
- `pc`+4 is modulo 2^`WORD_SIZE`: 0xFFFFFFFC wraps to 0x00000000 with no flag.

Operating modes, derived from `count`/`inflight`:
- **FILL**: `count`<`DEPTH`−1, issuing every edge.
- **FULL**: credits exhausted, `pc` held, `imem_addr` stable.
- **FLUSH**: the single edge with `redirect_valid`=1.

Other rules:
- The memory has no enable. Stalling holds `imem_addr`, and re-reading the same address is harmless.
- Reset mid-operation asynchronously clears all state; the in-flight word is lost.

## Timing
Reset values:
- `imem_addr`=`RESET_ADDR`, `out_valid`=0, `out_instr`=0, `out_pc`=0.
- `count`=0, `inflight`=0.

Latency:
- First issue happens at the first edge after `rst_n` deasserts (E1).
- The instruction at `RESET_ADDR` is captured at E2, and `out_valid`=1 after E2.
- Redirect at edge R: the target is issued at R+1 and captured at R+2, with `out_valid` for the target after R+2. The redirect penalty is 2 cycles.

Throughput:
- With `out_ready`=1 held, one instruction per cycle is sustained with consecutive PCs.
- When `out_ready` drops, at most one more word lands: the in-flight one. The FIFO then holds `DEPTH` entries, and `pc` freezes at the next unissued address.
- When `out_ready` rises, the first new issue is at that same edge. Back-to-back delivery resumes with no bubble when `DEPTH`≥2.

## Test plan
- **Reset and stream**: memory holds word k = 0x1000_0000+k, `RESET_ADDR`=0, `out_ready`=1. Required: `out_valid` after E2; `out_pc` 0,4,8,…; `out_instr` 0x10000000,0x10000001,… on every cycle.
- **Backpressure**: `out_ready`=0 for 5 cycles mid-stream. Required:
  - `count` reaches 2 and `imem_addr` stays stable.
  - On release, no PC is skipped or duplicated and there is no bubble.
- **Redirect**: `redirect_addr`=0x0000_0040 while streaming at pc 0x10. Required:
  - `out_valid`=0 on the redirect cycle and the next two.
  - Then `out_pc` 0x40, 0x44, …, and the stale 0x10-area word never appears.
- **Redirect during stall**: FIFO full with `out_ready`=0, and `redirect_valid` pulsed with target 0x0000_0103. Required: flush, then first `out_pc`=0x100.
- **Wrap**: redirect to 0xFFFF_FFF8. Required: `out_pc` sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- **Async reset mid-stream**: `rst_n` dropped between edges. Required:
  - Outputs are at reset values immediately, with no clock edge needed.
  - After release, the stream restarts at `RESET_ADDR`.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch requester with credit-limited fetch buffer
// Issues one word address per cycle and buffers returned instructions for decode.
module instruction_fetch #(
  parameter int                   WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] RESET_ADDR = '0,
  parameter int                   DEPTH      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [WORD_SIZE-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_SIZE-1:0] pc;
  logic                 inflight;
  logic [WORD_SIZE-1:0] inflight_pc;
  logic [WORD_SIZE-1:0] instr_q [DEPTH];
  logic [WORD_SIZE-1:0] pc_q    [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;

  logic                 pop;
  logic                 issue;
  logic [CW:0]          credit;
  logic [WORD_SIZE-1:0] target;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign imem_addr = pc;
  assign out_valid = (count != '0) & ~redirect_valid;
  assign out_instr = instr_q[head];
  assign out_pc    = pc_q[head];
  assign pop       = out_valid & out_ready;
  assign target    = redirect_addr & ~WORD_SIZE'(3);

  // The in-flight word already owns a slot, so capture never needs room of its own.
  assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue  = credit < (CW+1)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (redirect_valid) begin
      pc       <= target;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (inflight) begin
        instr_q[tail] <= instruction;
        pc_q[tail]    <= inflight_pc;
        tail          <= ptr_next(tail);
      end
      if (pop) begin
        head <= ptr_next(head);
      end
      count <= count + CW'(inflight) - CW'(pop);
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + WORD_SIZE'(4);
      end else begin
        inflight <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - bench for instruction_fetch
// Queue-based reference model checked every negedge, plus directed literal expectations.
module tb_instruction_fetch;

  localparam int          DEPTH      = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] instruction = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.WORD_SIZE(32), .RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Instruction memory with one-cycle read latency and no enable.
  always @(posedge clk) instruction <= word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: buffered words, one optional outstanding read, next fetch address.
  logic [31:0] m_pc_q[$];
  logic [31:0] m_in_q[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_pc = RESET_ADDR;
  bit          m_ev;
  bit          m_pop;
  int          m_credit;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc_q.delete();
      m_in_q.delete();
      m_infl = 1'b0;
      m_pc   = RESET_ADDR;
    end
    m_ev = (m_pc_q.size() != 0) && !redirect_valid;
    chk("model imem_addr", imem_addr, m_pc);
    chk("model out_valid", 32'(out_valid), 32'(m_ev));
    if (m_ev) begin
      chk("model out_pc", out_pc, m_pc_q[0]);
      chk("model out_instr", out_instr, m_in_q[0]);
    end else if (!rst_n) begin
      chk("reset out_pc", out_pc, 32'h0);
      chk("reset out_instr", out_instr, 32'h0);
    end
    if (rst_n) begin
      if (redirect_valid) begin
        m_pc_q.delete();
        m_in_q.delete();
        m_infl = 1'b0;
        m_pc   = redirect_addr & ~32'h3;
      end else begin
        m_pop    = m_ev && out_ready;
        m_credit = m_pc_q.size() + int'(m_infl) - int'(m_pop);
        if (m_pop) begin
          void'(m_pc_q.pop_front());
          void'(m_in_q.pop_front());
        end
        if (m_infl) begin
          m_pc_q.push_back(m_infl_pc);
          m_in_q.push_back(word(m_infl_pc));
        end
        if (m_credit < DEPTH) begin
          m_infl    = 1'b1;
          m_infl_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end else begin
          m_infl = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    #1;
    chk("redirect cycle out_valid", 32'(out_valid), 32'h0);
    step();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] held_addr;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("E1 imem_addr", imem_addr, 32'h4);
    chk("E1 out_valid", 32'(out_valid), 32'h0);
    step();
    chk("E2 out_valid", 32'(out_valid), 32'h1);
    chk("E2 out_pc", out_pc, 32'h0);
    chk("E2 out_instr", out_instr, 32'h1000_0000);
    step();
    chk("E3 out_pc", out_pc, 32'h4);
    chk("E3 out_instr", out_instr, 32'h1000_0001);
    repeat (3) step();

    // Backpressure: pc freezes one edge after ready drops.
    out_ready = 1'b0;
    step();
    held_addr = imem_addr;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall imem_addr stable", imem_addr, held_addr);
      chk("stall out_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    repeat (4) step();

    // Redirect while streaming.
    do_redirect(32'h0000_0040);
    chk("R out_valid", 32'(out_valid), 32'h0);
    step();
    chk("R+1 out_valid", 32'(out_valid), 32'h0);
    step();
    chk("R+2 out_valid", 32'(out_valid), 32'h1);
    chk("R+2 out_pc", out_pc, 32'h40);
    chk("R+2 out_instr", out_instr, 32'h1000_0010);
    step();
    chk("R+3 out_pc", out_pc, 32'h44);
    repeat (2) step();

    // Redirect into a full, stalled buffer with an unaligned target.
    out_ready = 1'b0;
    repeat (4) step();
    do_redirect(32'h0000_0103);
    chk("stall redirect imem_addr", imem_addr, 32'h100);
    step();
    step();
    chk("stall redirect out_pc", out_pc, 32'h100);
    chk("stall redirect out_instr", out_instr, 32'h1000_0040);
    out_ready = 1'b1;
    repeat (3) step();

    // Address wrap.
    do_redirect(32'hFFFF_FFF8);
    step();
    step();
    chk("wrap pc0", out_pc, 32'hFFFF_FFF8);
    chk("wrap instr0", out_instr, 32'h4FFF_FFFE);
    step();
    chk("wrap pc1", out_pc, 32'hFFFF_FFFC);
    chk("wrap instr1", out_instr, 32'h4FFF_FFFF);
    step();
    chk("wrap pc2", out_pc, 32'h0000_0000);
    chk("wrap instr2", out_instr, 32'h1000_0000);
    repeat (3) step();

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async imem_addr", imem_addr, RESET_ADDR);
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async out_pc", out_pc, 32'h0);
    chk("async out_instr", out_instr, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    step();
    chk("restart out_pc", out_pc, RESET_ADDR);
    chk("restart out_instr", out_instr, 32'h1000_0000);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
